// File: rtl/sd_ramdisk_responder.sv
// rtl/sd_ramdisk_responder.sv - RAM-backed responder for the sd_rd/sd_wr/sd_ack sector protocol.
// Optional write protection per drive is enabled with `define SD_RAMDISK_WRPROT_EN (adds the wp input).
module sd_ramdisk_responder #(
  parameter int VDNUM     = 3,
  parameter int DRV_SHIFT = 20,
  parameter int MEM_AW    = 22
) (
  input  logic              CLK,
  input  logic              RESET_N,
`ifdef SD_RAMDISK_WRPROT_EN
  input  logic [VDNUM-1:0]  wp,
`endif
  input  logic [31:0]       sd_lba,
  input  logic [VDNUM-1:0]  sd_rd,
  input  logic [VDNUM-1:0]  sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_RD_REQ, S_RD_PUT, S_WR_ADDR, S_WR_CAP, S_WR_REQ, S_FIN
  } state_t;

  state_t              state, state_nxt;
  logic [VDNUM-1:0]    prv_rd, prv_wr, pend_rd, pend_wr, clr_rd, clr_wr;
  logic [1:0]          drv, sel_drv;
  logic [MEM_AW-10:0]  lba_q;
  logic [8:0]          idx;
  logic                is_rd, skip;
  logic                found, sel_rd, accept, lba_oor, wp_hit, mem_done;

  // Walk downward so the lowest pending drive is the last (winning) match.
  always_comb begin
    found   = 1'b0;
    sel_drv = 2'd0;
    sel_rd  = 1'b0;
    for (int d = VDNUM - 1; d >= 0; d--) begin
      if (pend_rd[d] || pend_wr[d]) begin
        found   = 1'b1;
        sel_drv = d[1:0];
        sel_rd  = pend_rd[d];
      end
    end
  end

  assign accept  = (state == S_IDLE) && found;
  assign lba_oor = |(sd_lba >> (DRV_SHIFT - 9));

`ifdef SD_RAMDISK_WRPROT_EN
  assign wp_hit = !sel_rd && wp[sel_drv];
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    clr_rd = '0;
    clr_wr = '0;
    if (accept) begin
      if (sel_rd) clr_rd[sel_drv] = 1'b1;
      else        clr_wr[sel_drv] = 1'b1;
    end
  end

  // Skipped (out-of-range or protected) transfers complete each memory step without a request.
  assign mem_done = skip || mem_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_ACK;
      S_ACK:     state_nxt = is_rd ? S_RD_REQ : S_WR_ADDR;
      S_RD_REQ:  if (mem_done) state_nxt = S_RD_PUT;
      S_RD_PUT:  state_nxt = (idx == 9'd511) ? S_FIN : S_RD_REQ;
      S_WR_ADDR: state_nxt = S_WR_CAP;
      S_WR_CAP:  state_nxt = S_WR_REQ;
      S_WR_REQ:  if (mem_done) state_nxt = (idx == 9'd511) ? S_FIN : S_WR_ADDR;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_IDLE;
      prv_rd       <= '0;
      prv_wr       <= '0;
      pend_rd      <= '0;
      pend_wr      <= '0;
      drv          <= 2'd0;
      lba_q        <= '0;
      idx          <= 9'd0;
      is_rd        <= 1'b0;
      skip         <= 1'b0;
      err          <= 1'b0;
      sd_buff_dout <= 8'd0;
      mem_wdata    <= 8'd0;
    end else begin
      state   <= state_nxt;
      prv_rd  <= sd_rd;
      prv_wr  <= sd_wr;
      pend_rd <= (pend_rd & ~clr_rd) | (sd_rd & ~prv_rd);
      pend_wr <= (pend_wr & ~clr_wr) | (sd_wr & ~prv_wr);
      if (accept) begin
        drv   <= sel_drv;
        lba_q <= sd_lba[MEM_AW-10:0];
        is_rd <= sel_rd;
        skip  <= lba_oor || wp_hit;
        err   <= lba_oor || wp_hit;
        idx   <= 9'd0;
      end
      if (state == S_RD_REQ && mem_done) sd_buff_dout <= skip ? 8'd0 : mem_rdata;
      if (state == S_WR_CAP) mem_wdata <= sd_buff_din;
      // idx wraps to 0 after the last byte, leaving it ready for the next sector.
      if (state == S_RD_PUT || (state == S_WR_REQ && mem_done)) idx <= idx + 9'd1;
    end
  end

  assign busy         = (state != S_IDLE);
  assign sd_ack       = (state != S_IDLE) && (state != S_FIN);
  assign sd_buff_addr = sd_ack ? idx : 9'd0;
  assign sd_buff_wr   = (state == S_RD_PUT);
  assign mem_rd       = (state == S_RD_REQ) && !skip;
  assign mem_wr       = (state == S_WR_REQ) && !skip;
  assign mem_addr     = (MEM_AW'(drv) << DRV_SHIFT) + {lba_q, 9'd0} + MEM_AW'(idx);

endmodule

// File: tb/tb_sd_ramdisk_responder.sv
// tb/tb_sd_ramdisk_responder.sv - randomized self-checking bench for sd_ramdisk_responder against a sector-level model.
module tb_sd_ramdisk_responder;

  logic        CLK, RESET_N;
  logic [31:0] sd_lba;
  logic [2:0]  sd_rd, sd_wr;
  logic        sd_ack, sd_buff_wr, sd_buff_din_dummy;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din;
  logic [21:0] mem_addr;
  logic        mem_rd, mem_wr, mem_ready, busy, err;
  logic [7:0]  mem_wdata, mem_rdata;
`ifdef SD_RAMDISK_WRPROT_EN
  logic [2:0]  wp;
`endif

  sd_ramdisk_responder #(.VDNUM(3), .DRV_SHIFT(20), .MEM_AW(22)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
`ifdef SD_RAMDISK_WRPROT_EN
    .wp(wp),
`endif
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total, bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Backing memory: untouched bytes follow a fixed address hash.
  logic [7:0] dev_mem [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] init_byte(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] dev_rd(input logic [21:0] a);
    return dev_mem.exists(int'(a)) ? dev_mem[int'(a)] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [21:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
  endfunction

  // Memory slave with programmable latency, plus protocol monitors.
  int          lat, lat_cnt, mem_rd_cnt, viol;
  logic [21:0] first_rd_addr, prev_addr;
  logic [7:0]  prev_wd;
  logic        prev_req, prev_rdy;
  logic [29:0] wlog [$];

  initial begin
    mem_ready = 1'b0; mem_rdata = 8'd0; lat_cnt = 0; viol = 0; mem_rd_cnt = 0;
    prev_req = 1'b0; prev_rdy = 1'b0; prev_addr = '0; prev_wd = '0; first_rd_addr = '0;
    forever begin
      @(negedge CLK);
      if (mem_rd && mem_wr) viol++;
      if ((mem_rd || mem_wr) && prev_req && !prev_rdy &&
          (mem_addr !== prev_addr || (mem_wr && mem_wdata !== prev_wd))) viol++;
      prev_req = mem_rd || mem_wr; prev_rdy = mem_ready;
      prev_addr = mem_addr; prev_wd = mem_wdata;
      if (mem_ready) mem_ready = 1'b0;
      else if (mem_rd || mem_wr) begin
        if (lat_cnt >= lat) begin
          mem_ready = 1'b1;
          lat_cnt = 0;
          if (mem_rd) begin
            if (mem_rd_cnt == 0) first_rd_addr = mem_addr;
            mem_rd_cnt++;
            mem_rdata = dev_rd(mem_addr);
          end else begin
            dev_mem[int'(mem_addr)] = mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
          end
        end else lat_cnt++;
      end else lat_cnt = 0;
    end
  end

  // Sector dpram: registered read port, q valid one cycle after the address.
  logic [7:0]  buff [0:511];
  logic [7:0]  snap [0:511];
  logic [16:0] strobes [$];
  logic [8:0]  b_a;
  logic        b_w;
  logic [7:0]  b_d;

  initial begin
    sd_buff_din = 8'd0;
    forever begin
      @(negedge CLK);
      b_a = sd_buff_addr; b_w = sd_buff_wr; b_d = sd_buff_dout;
      if (b_w) strobes.push_back({b_a, b_d});
      @(posedge CLK);
      #1;
      if (b_w) buff[b_a] = b_d;
      sd_buff_din = buff[b_a];
    end
  end

  task automatic clear_logs();
    strobes.delete();
    wlog.delete();
    mem_rd_cnt = 0;
  endtask

  task automatic fire(input logic [2:0] rmask, input logic [2:0] wmask, input bit hold, output int al);
    @(posedge CLK); #1;
    sd_rd = sd_rd | rmask;
    sd_wr = sd_wr | wmask;
    al = 99;
    for (int n = 1; n <= 8; n++) begin
      @(posedge CLK); #1;
      if (!hold) begin
        sd_rd = sd_rd & ~rmask;
        sd_wr = sd_wr & ~wmask;
      end
      if (sd_ack) begin
        al = n;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 10000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("busy_timeout", busy, 1'b0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hits;
    hits = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge CLK); #1;
      if (busy) hits++;
    end
    chk(tag, hits, 0);
  endtask

  // Sector-level expectation: 512 buffer strobes per read, 512 memory writes per accepted write.
  task automatic verify(input int drv, input bit rd, input int lba, input bit prot);
    logic [21:0] base;
    bit          skip;
    int          errs;
    base = 22'((drv << 20) + (lba << 9));
    skip = (lba >= 2048) || prot;
    errs = 0;
    chk("err_flag", err, skip);
    chk("ack_end", sd_ack, 1'b0);
    chk("addr_home", sd_buff_addr, 9'd0);
    if (rd) begin
      chk("rd_strobes", strobes.size(), 512);
      chk("rd_memrd", mem_rd_cnt, skip ? 0 : 512);
      for (int i = 0; i < strobes.size(); i++)
        if (strobes[i] !== {9'(i), skip ? 8'h00 : ref_rd(base + 22'(i))}) errs++;
      chk("rd_data", errs, 0);
    end else begin
      chk("wr_count", wlog.size(), skip ? 0 : 512);
      chk("wr_strobes", strobes.size(), 0);
      for (int i = 0; i < wlog.size(); i++)
        if (wlog[i] !== {base + 22'(i), snap[i]}) errs++;
      chk("wr_data", errs, 0);
      if (!skip)
        for (int i = 0; i < 512; i++) ref_mem[int'(base + 22'(i))] = snap[i];
    end
    chk("proto", viol, 0);
    clear_logs();
  endtask

  task automatic take_snap();
    for (int i = 0; i < 512; i++) snap[i] = buff[i];
  endtask

  int al, n;
  int lbas [6];

  initial begin
    total = 0; bad = 0;
    RESET_N = 1'b0; sd_rd = '0; sd_wr = '0; sd_lba = '0; lat = 1;
`ifdef SD_RAMDISK_WRPROT_EN
    wp = 3'b000;
`endif
    for (int i = 0; i < 512; i++) buff[i] = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", {sd_ack, busy, err, mem_rd, mem_wr, sd_buff_wr, sd_buff_addr,
                       sd_buff_dout, mem_addr, mem_wdata}, 64'd0);
    @(negedge CLK) RESET_N = 1'b1;

    // Read drive1 lba5, slow memory.
    for (int i = 0; i < 512; i++) begin
      ref_mem[32'h100A00 + i] = 8'(i) ^ 8'hA5;
      dev_mem[32'h100A00 + i] = 8'(i) ^ 8'hA5;
    end
    lat = 3; sd_lba = 32'd5; clear_logs();
    fire(3'b000, 3'b000, 0, al);
    chk("no_req_no_ack", al, 99);
    fire(3'b010, 3'b000, 0, al);
    chk("ack_latency", al, 2);
    wait_idle();
    chk("rd_base", first_rd_addr, 22'h100A00);
    verify(1, 1, 5, 0);

    // Write drive0 lba0 from a ramp buffer.
    for (int i = 0; i < 512; i++) buff[i] = 8'(i);
    take_snap();
    lat = 1; sd_lba = 32'd0;
    fire(3'b000, 3'b001, 0, al);
    chk("ack_latency_wr", al, 2);
    wait_idle();
    verify(0, 0, 0, 0);

    // Simultaneous edges: drive0 write must precede drive2 read.
    for (int i = 0; i < 512; i++) buff[i] = 8'($urandom);
    take_snap();
    sd_lba = 32'd7; lat = 0;
    fire(3'b100, 3'b001, 0, al);
    chk("cont_ack", al, 2);
    wait_idle();
    verify(0, 0, 7, 0);
    n = 0;
    while (!busy && n < 5) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("cont_second", busy, 1'b1);
    wait_idle();
    verify(2, 1, 7, 0);
    quiet("cont_pend_clear", 20);

    // Out-of-range read with the level held high; then a valid read clears err.
    sd_lba = 32'd2048; lat = 1;
    fire(3'b001, 3'b000, 1, al);
    wait_idle();
    verify(0, 1, 2048, 0);
    quiet("no_retrigger", 10);
    sd_rd = 3'b000;
    sd_lba = 32'd1;
    fire(3'b001, 3'b000, 0, al);
    chk("err_cleared", err, 1'b0);
    wait_idle();
    verify(0, 1, 1, 0);

    // Reset in the middle of a read.
    sd_lba = 32'd3; lat = 0;
    fire(3'b010, 3'b000, 0, al);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(sd_ack && sd_buff_addr == 9'd100) && n < 4000);
    chk("reach_idx100", sd_buff_addr, 9'd100);
    RESET_N = 1'b0;
    #1;
    chk("reset_mid", {sd_ack, busy, err, mem_rd, mem_wr, sd_buff_wr, sd_buff_addr,
                      sd_buff_dout, mem_addr, mem_wdata}, 64'd0);
    @(negedge CLK) RESET_N = 1'b1;
    quiet("no_resume", 30);
    clear_logs();

`ifdef SD_RAMDISK_WRPROT_EN
    wp = 3'b001;
    for (int i = 0; i < 512; i++) buff[i] = 8'($urandom);
    take_snap();
    sd_lba = 32'd2;
    fire(3'b000, 3'b001, 0, al);
    wait_idle();
    verify(0, 0, 2, 1);
    wp = 3'b000;
`endif

    // Random sectors over overlapping addresses.
    lbas[0] = 0; lbas[1] = 1; lbas[2] = 5; lbas[3] = 7; lbas[4] = 2047; lbas[5] = 2048;
    for (int t = 0; t < 8; t++) begin
      int  drv, lba;
      bit  rd;
      drv = int'($urandom_range(0, 2));
      rd  = 1'($urandom_range(0, 1));
      lba = lbas[$urandom_range(0, 5)];
      if (lba == 2048) lba = lba + int'($urandom_range(0, 100));
      lat = int'($urandom_range(0, 2));
      if (!rd) for (int i = 0; i < 512; i++) buff[i] = 8'($urandom);
      take_snap();
      sd_lba = 32'(lba);
      if (rd) fire(3'(1 << drv), 3'b000, 0, al);
      else    fire(3'b000, 3'(1 << drv), 0, al);
      chk("rand_ack", al, 2);
      wait_idle();
      verify(drv, rd, lba, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
